// File: rtl/multdiv_pkg.sv
// Shared definitions for the multdiv unit.
//   divState_t     - sequencer states of the iterative divider
//   counterWidth() - bits needed to count 0..width
//   DIV_BY_ZERO_Q  - quotient returned on a zero divisor (all ones, sliced to WIDTH)
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } divState_t;

  function automatic int unsigned counterWidth(input int unsigned width);
    return $clog2(width + 1);
  endfunction

  localparam logic [63:0] DIV_BY_ZERO_Q = '1;

endpackage

// File: rtl/twos_negate.sv
// Conditional two's-complement negator.
//   dataIn  - operand
//   negate  - 1 selects -dataIn, 0 passes dataIn through
//   dataOut - result, same width as dataIn
module twos_negate #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] dataIn,
  input  logic             negate,
  output logic [WIDTH-1:0] dataOut
);

  assign dataOut = negate ? ('0 - dataIn) : dataIn;

endmodule

// File: rtl/divider_seq.sv
// Multi-cycle non-restoring integer divider, signed or unsigned per operation.
//   clock, reset_n     - rising-edge clock, asynchronous active-low reset
//   start              - request; accepted in IDLE or DONE only
//   signed_mode        - 1 = two's-complement operands, sampled with start
//   dividend, divisor  - operands, sampled on the accepting edge
//   busy               - high while iterating (RUN) and correcting (FIX)
//   result_ready       - one-cycle pulse while quotient/remainder are fresh
//   quotient/remainder - registered results, held until the next result
//   div_by_zero        - registered, set with the result of a zero-divisor request
module divider_seq
  import multdiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             result_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = counterWidth(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  divState_t state, nextState;

  logic [WIDTH:0]   aReg;        // partial remainder, one guard bit for full unsigned range
  logic [WIDTH-1:0] qReg;
  logic [WIDTH-1:0] mReg;        // divisor magnitude
  logic             negDividend;
  logic             negDivisor;
  logic [CW-1:0]    counter;

  logic accept, divZero, inFix;
  logic dividendNeg, divisorNeg;

  assign accept      = start && ((state == IDLE) || (state == DONE));
  assign divZero     = (divisor == '0);
  assign inFix       = (state == FIX);
  assign dividendNeg = signed_mode & dividend[WIDTH-1];
  assign divisorNeg  = signed_mode & divisor[WIDTH-1];

  // One negator serves both the dividend magnitude (on the accepting edge)
  // and the quotient sign fix (in FIX); the two uses never overlap in time.
  logic [WIDTH-1:0] negAIn, negAOut;
  logic             negASel;
  logic [WIDTH-1:0] divisorMag;
  logic [WIDTH-1:0] remMag, remFixed;

  assign negAIn  = inFix ? qReg : dividend;
  assign negASel = inFix ? (negDividend ^ negDivisor) : dividendNeg;

  twos_negate #(.WIDTH(WIDTH)) uNegShared (
    .dataIn  (negAIn),
    .negate  (negASel),
    .dataOut (negAOut)
  );

  twos_negate #(.WIDTH(WIDTH)) uNegDivisor (
    .dataIn  (divisor),
    .negate  (divisorNeg),
    .dataOut (divisorMag)
  );

  // Final restore step; the true result is in [0, M) so WIDTH bits suffice.
  assign remMag = aReg[WIDTH] ? (aReg[WIDTH-1:0] + mReg) : aReg[WIDTH-1:0];

  twos_negate #(.WIDTH(WIDTH)) uNegRemainder (
    .dataIn  (remMag),
    .negate  (negDividend),
    .dataOut (remFixed)
  );

  // Non-restoring step: intermediate overflow of the shifted value wraps,
  // but the post-add/sub result always lands back in [-M, M).
  logic [WIDTH:0]   shifted, mExt, aStep;
  logic [WIDTH-1:0] qStep;

  always_comb begin
    shifted = {aReg[WIDTH-1:0], qReg[WIDTH-1]};
    mExt    = {1'b0, mReg};
    aStep   = aReg[WIDTH] ? (shifted + mExt) : (shifted - mExt);
    qStep   = {qReg[WIDTH-2:0], ~aStep[WIDTH]};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (start) nextState = divZero ? DONE : RUN;
      RUN:  if (counter == LAST_STEP) nextState = FIX;
      FIX:  nextState = DONE;
      DONE: nextState = start ? (divZero ? DONE : RUN) : IDLE;
      default: nextState = IDLE;
    endcase
  end

  assign busy         = (state == RUN) || (state == FIX);
  assign result_ready = (state == DONE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      aReg        <= '0;
      qReg        <= '0;
      mReg        <= '0;
      negDividend <= 1'b0;
      negDivisor  <= 1'b0;
      counter     <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      if (divZero) begin
        quotient    <= DIV_BY_ZERO_Q[WIDTH-1:0];
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end else begin
        negDividend <= dividendNeg;
        negDivisor  <= divisorNeg;
        mReg        <= divisorMag;
        aReg        <= '0;
        qReg        <= negAOut;
        counter     <= '0;
      end
    end else begin
      case (state)
        RUN: begin
          aReg    <= aStep;
          qReg    <= qStep;
          counter <= counter + CW'(1);
        end
        FIX: begin
          quotient    <= negAOut;
          remainder   <= remFixed;
          div_by_zero <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_seq.sv
// Directed self-checking bench for divider_seq (WIDTH=32 and WIDTH=8 instances).
module tb_divider_seq;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  logic        start32 = 1'b0, sm32 = 1'b0;
  logic [31:0] dd32 = '0, dv32 = '0;
  logic        busy32, ready32, dz32;
  logic [31:0] q32, r32;

  logic        start8 = 1'b0, sm8 = 1'b0;
  logic [7:0]  dd8 = '0, dv8 = '0;
  logic        busy8, ready8, dz8;
  logic [7:0]  q8, r8;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clock = ~clock;

  divider_seq #(.WIDTH(32)) dut32 (
    .clock(clock), .reset_n(reset_n), .start(start32), .signed_mode(sm32),
    .dividend(dd32), .divisor(dv32), .busy(busy32), .result_ready(ready32),
    .quotient(q32), .remainder(r32), .div_by_zero(dz32)
  );

  divider_seq #(.WIDTH(8)) dut8 (
    .clock(clock), .reset_n(reset_n), .start(start8), .signed_mode(sm8),
    .dividend(dd8), .divisor(dv8), .busy(busy8), .result_ready(ready8),
    .quotient(q8), .remainder(r8), .div_by_zero(dz8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Call at a negedge. Launches one request, optionally re-pulses start with
  // 7/7 at sample pokeAt, and returns at the sample where result_ready is seen.
  // Sample k is taken at the negedge following the k-th edge after acceptance.
  task automatic goDiv(input bit use8, input logic sm, input logic [63:0] dd,
                       input logic [63:0] dv, input int pokeAt,
                       output int lat, output logic [63:0] q, output logic [63:0] r,
                       output logic dz, output int busyBad);
    logic rdy, bsy;
    if (use8) begin start8 = 1'b1; sm8 = sm; dd8 = dd[7:0]; dv8 = dv[7:0]; end
    else      begin start32 = 1'b1; sm32 = sm; dd32 = dd[31:0]; dv32 = dv[31:0]; end
    @(posedge clock); #1;
    start8 = 1'b0; start32 = 1'b0;
    lat = -1; busyBad = 0; q = '0; r = '0; dz = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      rdy = use8 ? ready8 : ready32;
      bsy = use8 ? busy8 : busy32;
      if (rdy) begin
        lat = k;
        q   = use8 ? {56'd0, q8} : {32'd0, q32};
        r   = use8 ? {56'd0, r8} : {32'd0, r32};
        dz  = use8 ? dz8 : dz32;
        if (bsy) busyBad++;
        break;
      end
      if (!bsy) busyBad++;
      if (k == pokeAt) begin
        if (use8) begin start8 = 1'b1; dd8 = 8'd7; dv8 = 8'd7; end
        else      begin start32 = 1'b1; dd32 = 32'd7; dv32 = 32'd7; end
        @(posedge clock); #1;
        start8 = 1'b0; start32 = 1'b0;
      end
    end
  endtask

  typedef struct {
    string       tag;
    bit          use8;
    logic        sm;
    logic [63:0] dd, dv, q, r;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int lat, busyBad, readyCount;
    logic [63:0] q, r;
    logic dz;

    // Reset state
    #2;
    check("rst_q", q32, 0);
    check("rst_r", r32, 0);
    check("rst_dz", dz32, 0);
    check("rst_ready", ready32, 0);
    check("rst_busy", busy32, 0);
    #10 reset_n = 1'b1;

    // Basic unsigned with latency, busy window, single-cycle pulse and hold
    @(negedge clock);
    goDiv(0, 0, 100, 7, -1, lat, q, r, dz, busyBad);
    check("u100_7_lat", lat, 33);
    check("u100_7_q", q, 14);
    check("u100_7_r", r, 2);
    check("u100_7_dz", dz, 0);
    check("u100_7_busy", busyBad, 0);
    @(negedge clock);
    check("u100_7_pulse", ready32, 0);
    repeat (4) @(negedge clock);
    check("u100_7_hold", q32, 14);

    vecs.push_back('{"s-100_7",  0, 1, 64'hFFFFFF9C, 64'd7,        64'hFFFFFFF2, 64'hFFFFFFFE, 0, 33});
    vecs.push_back('{"s100_-7",  0, 1, 64'd100,      64'hFFFFFFF9, 64'hFFFFFFF2, 64'd2,        0, 33});
    vecs.push_back('{"s-7_-2",   0, 1, 64'hFFFFFFF9, 64'hFFFFFFFE, 64'd3,        64'hFFFFFFFF, 0, 33});
    vecs.push_back('{"u5_0",     0, 0, 64'd5,        64'd0,        64'hFFFFFFFF, 64'd5,        1, 0});
    vecs.push_back('{"u9_3",     0, 0, 64'd9,        64'd3,        64'd3,        64'd0,        0, 33});
    vecs.push_back('{"s-5_0",    0, 1, 64'hFFFFFFFB, 64'd0,        64'hFFFFFFFF, 64'hFFFFFFFB, 1, 0});
    vecs.push_back('{"s_ovf",    0, 1, 64'h80000000, 64'hFFFFFFFF, 64'h80000000, 64'd0,        0, 33});
    vecs.push_back('{"u_max_1",  0, 0, 64'hFFFFFFFF, 64'd1,        64'hFFFFFFFF, 64'd0,        0, 33});
    vecs.push_back('{"u_max_msb",0, 0, 64'hFFFFFFFF, 64'h80000000, 64'd1,        64'h7FFFFFFF, 0, 33});
    vecs.push_back('{"w8_200_3", 1, 0, 64'd200,      64'd3,        64'd66,       64'd2,        0, 9});
    vecs.push_back('{"w8_255_16",1, 0, 64'd255,      64'd16,       64'd15,       64'd15,       0, 9});
    vecs.push_back('{"w8_ovf",   1, 1, 64'h80,       64'hFF,       64'h80,       64'd0,        0, 9});
    vecs.push_back('{"w8_-7_2",  1, 1, 64'hF9,       64'h02,       64'hFD,       64'hFF,       0, 9});

    foreach (vecs[i]) begin
      @(negedge clock);
      goDiv(vecs[i].use8, vecs[i].sm, vecs[i].dd, vecs[i].dv, -1, lat, q, r, dz, busyBad);
      check({vecs[i].tag, "_q"}, q, vecs[i].q);
      check({vecs[i].tag, "_r"}, r, vecs[i].r);
      check({vecs[i].tag, "_dz"}, dz, vecs[i].dz);
      check({vecs[i].tag, "_busy"}, busyBad, 0);
      if (vecs[i].dz) check({vecs[i].tag, "_lat_le1"}, (lat >= 0 && lat <= 1), 1);
      else            check({vecs[i].tag, "_lat"}, lat, vecs[i].lat);
    end

    // start while busy is ignored (re-pulse lands on edge 10)
    @(negedge clock);
    goDiv(0, 0, 1000, 10, 9, lat, q, r, dz, busyBad);
    check("ign_lat", lat, 33);
    check("ign_q", q, 100);
    check("ign_r", r, 0);
    // back-to-back: request issued in the DONE cycle
    goDiv(0, 0, 7, 7, -1, lat, q, r, dz, busyBad);
    check("b2b_lat", lat, 33);
    check("b2b_q", q, 1);
    check("b2b_r", r, 0);

    // Reset asserted just after edge 15 of an operation
    @(negedge clock);
    start32 = 1'b1; sm32 = 1'b0; dd32 = 32'd100; dv32 = 32'd7;
    @(posedge clock); #1 start32 = 1'b0;
    repeat (15) @(posedge clock);
    #1 reset_n = 1'b0;
    #1;
    check("arst_q", q32, 0);
    check("arst_r", r32, 0);
    check("arst_busy", busy32, 0);
    check("arst_ready", ready32, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    readyCount = 0;
    repeat (40) begin
      @(negedge clock);
      if (ready32) readyCount++;
    end
    check("arst_nopulse", readyCount, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
